layer_mac: RTL and testbench
============================

Name: layer_mac

Overview:
- Dense-layer compute stage sitting directly downstream of a source layer_ram (activations) and upstream of a destination layer_ram (next-layer activations).
- On a start pulse it walks all N_IN source activations for each of N_OUT neurons and multiply-accumulates them against signed weights from a weight ROM.
- Each finished sum goes through the output activation and is written into the destination RAM through its write port.
- Both RAM read ports have one cycle of read latency (registered address), and the block pipelines around that.

Parameters:
- D_WIDTH, 4: activation width, unsigned; also the width of the written result.
- W_WIDTH, 4: weight width, signed two's complement.
- A_WIDTH, 4: source/destination RAM address width.
- WA_WIDTH, 8: weight ROM address width.
- N_IN, 16: inputs per neuron, 1..2**A_WIDTH.
- N_OUT, 4: neurons in the layer, 1..2**A_WIDTH.
- ACC_WIDTH, 16: signed accumulator width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to compute the whole layer.
- busy  out  1  high from the cycle after start is accepted until the return to IDLE.
- done  out  1  one-cycle pulse, the cycle after the last write.
- r_addr  out  A_WIDTH  read address to the source layer_ram.
- act_in  in  D_WIDTH  source layer_ram data_out; valid one cycle after r_addr.
- w_rom_addr  out  WA_WIDTH  weight address, equal to neuron*N_IN + idx.
- w_in  in  W_WIDTH  weight; valid one cycle after w_rom_addr.
- o_w_en  out  1  write enable to the destination layer_ram.
- o_w_addr  out  A_WIDTH  destination address, equal to the neuron index.
- o_data  out  D_WIDTH  activated result.

Behaviour:
- Reset (synchronous, active-high) drives:
  - state IDLE;
  - idx, neuron and acc to 0;
  - busy, done, o_w_en and mac_v to 0;
  - r_addr, w_rom_addr, o_w_addr and o_data to 0.
- Reset mid-operation aborts immediately; no partial or further write is issued.
- FSM states: IDLE, RUN, DRAIN, WRITE.
- IDLE:
  - start=1 at an edge sets acc<=0, idx<=0, neuron<=0, moves to RUN.
  - start in any other state is ignored.
- RUN:
  - r_addr=idx and w_rom_addr=neuron*N_IN+idx, driven from registers.
  - Each edge increments idx.
  - After the edge where idx==N_IN-1, move to DRAIN.
- mac_v is a registered copy of (state==RUN).
- When mac_v=1, acc <= acc + sext(zext(act_in) * sext(w_in)) at each edge.
  - Product width is D_WIDTH+W_WIDTH+1, signed.
  - Accumulation wraps modulo 2**ACC_WIDTH.
- DRAIN: one cycle; the last product is accumulated at its closing edge; then move to WRITE.
- WRITE:
  - o_w_en=1, o_w_addr=neuron, o_data=act(acc) for exactly one cycle, all combinational from registers.
  - At the closing edge acc<=0 and idx<=0.
  - If neuron==N_OUT-1: go to IDLE and pulse done the following cycle.
  - Otherwise: neuron<=neuron+1 and go to RUN.
- Timing:
  - Each neuron takes N_IN+2 cycles.
  - The first write appears N_IN+2 cycles after the start edge.
  - done appears N_OUT*(N_IN+2)+1 cycles after the start edge.
- In IDLE, r_addr and w_rom_addr hold 0; o_w_en is never high outside WRITE.
- start coincident with rst: rst wins.

Optional Feature:
- Macro: LAYER_MAC_RELU_EN.
- Defined: act(acc) = 0 if acc<0; 2**D_WIDTH-1 if acc>2**D_WIDTH-1; otherwise acc[D_WIDTH-1:0]. This is ReLU with unsigned saturation.
- Undefined: act(acc) = acc saturated to the signed range [-2**(D_WIDTH-1), 2**(D_WIDTH-1)-1] and emitted as two's complement. This is linear output with no ReLU.

Test Plan:
- Ones (N_IN=4, N_OUT=2, all act=1, all w=1):
  - o_data=4 at addresses 0 and 1;
  - o_w_en high exactly 2 cycles, 6 cycles apart, the first 6 cycles after start;
  - done 13 cycles after start.
- Mixed (RELU_EN, N_IN=4, acts {1,2,3,4}, weights {2,-1,1,0}):
  - acc=3, o_data=3.
- Saturation and negative, both builds (acts all 15, w all 7):
  - acc=420, o_data=15 with RELU_EN, 7 without.
  - With acts all 3 and w all -1: acc=-12, o_data=0 with RELU_EN, 4'b1000 (-8) without.
- Start while busy:
  - start pulsed during RUN of neuron 0 is ignored: same writes, same done timing.
  - A start after done recomputes identically.
- Reset mid-op:
  - rst during RUN of neuron 1: no further o_w_en; busy=0 and done=0 after the reset edge.
  - A subsequent start produces the full, correct result set.

Source files
------------

// File: rtl/layer_mac.sv
// rtl/layer_mac.sv - dense-layer multiply-accumulate stage between two layer RAMs
// Optional LAYER_MAC_RELU_EN selects ReLU with unsigned saturation; default is signed saturation.
module layer_mac #(
  parameter int D_WIDTH   = 4,
  parameter int W_WIDTH   = 4,
  parameter int A_WIDTH   = 4,
  parameter int WA_WIDTH  = 8,
  parameter int N_IN      = 16,
  parameter int N_OUT     = 4,
  parameter int ACC_WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic [A_WIDTH-1:0]  r_addr,
  input  logic [D_WIDTH-1:0]  act_in,
  output logic [WA_WIDTH-1:0] w_rom_addr,
  input  logic [W_WIDTH-1:0]  w_in,
  output logic                o_w_en,
  output logic [A_WIDTH-1:0]  o_w_addr,
  output logic [D_WIDTH-1:0]  o_data
);

  localparam int PW = D_WIDTH + W_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, WRITE} state_t;

  state_t state, state_next;

  logic [A_WIDTH-1:0]          idx;
  logic [A_WIDTH-1:0]          neuron;
  logic signed [ACC_WIDTH-1:0] acc;
  logic                        mac_v;

  logic signed [PW-1:0]        a_ext;
  logic signed [PW-1:0]        w_ext;
  logic signed [PW-1:0]        prod;
  logic signed [ACC_WIDTH-1:0] prod_ext;
  logic [D_WIDTH-1:0]          act_val;
  logic                        last_idx;
  logic                        last_neuron;

  assign last_idx    = (idx == A_WIDTH'(N_IN - 1));
  assign last_neuron = (neuron == A_WIDTH'(N_OUT - 1));

  // Activation is unsigned, weight is signed; the product always fits in PW bits.
  assign a_ext    = {{(PW - D_WIDTH){1'b0}}, act_in};
  assign w_ext    = {{(PW - W_WIDTH){w_in[W_WIDTH-1]}}, w_in};
  assign prod     = a_ext * w_ext;
  assign prod_ext = {{(ACC_WIDTH - PW){prod[PW-1]}}, prod};

`ifdef LAYER_MAC_RELU_EN
  localparam logic signed [ACC_WIDTH-1:0] ACC_ZERO = '0;
  localparam logic signed [ACC_WIDTH-1:0] U_MAX    = ACC_WIDTH'(2**D_WIDTH - 1);

  always_comb begin
    act_val = acc[D_WIDTH-1:0];
    if (acc < ACC_ZERO) begin
      act_val = '0;
    end else if (acc > U_MAX) begin
      act_val = '1;
    end
  end
`else
  localparam logic signed [ACC_WIDTH-1:0] S_MAX = ACC_WIDTH'(2**(D_WIDTH-1) - 1);
  localparam logic signed [ACC_WIDTH-1:0] S_MIN = ACC_WIDTH'(-(2**(D_WIDTH-1)));

  always_comb begin
    act_val = acc[D_WIDTH-1:0];
    if (acc > S_MAX) begin
      act_val = S_MAX[D_WIDTH-1:0];
    end else if (acc < S_MIN) begin
      act_val = S_MIN[D_WIDTH-1:0];
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    r_addr     = '0;
    w_rom_addr = '0;
    o_w_en     = 1'b0;
    o_w_addr   = '0;
    o_data     = '0;
    case (state)
      IDLE: begin
        if (start) state_next = RUN;
      end
      RUN: begin
        r_addr     = idx;
        w_rom_addr = WA_WIDTH'(neuron) * WA_WIDTH'(N_IN) + WA_WIDTH'(idx);
        if (last_idx) state_next = DRAIN;
      end
      DRAIN: begin
        state_next = WRITE;
      end
      WRITE: begin
        o_w_en     = 1'b1;
        o_w_addr   = neuron;
        o_data     = act_val;
        state_next = last_neuron ? IDLE : RUN;
      end
      default: state_next = IDLE;
    endcase
  end

  // mac_v lags RUN by one cycle to line up with the one-cycle RAM/ROM read latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx    <= '0;
      neuron <= '0;
      acc    <= '0;
      mac_v  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      mac_v <= (state == RUN);
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            acc    <= '0;
            idx    <= '0;
            neuron <= '0;
            busy   <= 1'b1;
          end
        end
        RUN: begin
          idx <= idx + A_WIDTH'(1);
          if (mac_v) acc <= acc + prod_ext;
        end
        DRAIN: begin
          if (mac_v) acc <= acc + prod_ext;
        end
        WRITE: begin
          acc <= '0;
          idx <= '0;
          if (last_neuron) begin
            busy <= 1'b0;
            done <= 1'b1;
          end else begin
            neuron <= neuron + A_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_layer_mac.sv
// tb/tb_layer_mac.sv - directed self-checking bench for layer_mac (N_IN=4, N_OUT=2)
module tb_layer_mac;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       busy;
  logic       done;
  logic [3:0] r_addr;
  logic [3:0] act_in;
  logic [7:0] w_rom_addr;
  logic [3:0] w_in;
  logic       o_w_en;
  logic [3:0] o_w_addr;
  logic [3:0] o_data;

  layer_mac #(.N_IN(4), .N_OUT(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .r_addr     (r_addr),
    .act_in     (act_in),
    .w_rom_addr (w_rom_addr),
    .w_in       (w_in),
    .o_w_en     (o_w_en),
    .o_w_addr   (o_w_addr),
    .o_data     (o_data)
  );

  always #5 clk = ~clk;

  logic [3:0] act_mem [0:15];
  logic [3:0] w_mem   [0:255];

  always @(posedge clk) begin
    act_in <= act_mem[r_addr];
    w_in   <= w_mem[w_rom_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         wr_cnt = 0;
  int         done_cnt = 0;
  int         done_cyc = 0;
  logic [3:0] wr_addr [0:63];
  logic [3:0] wr_data [0:63];
  logic [15:0] wr_acc [0:63];
  int         wr_cyc  [0:63];

  always @(negedge clk) begin
    if (o_w_en && wr_cnt < 64) begin
      wr_addr[wr_cnt] = o_w_addr;
      wr_data[wr_cnt] = o_data;
      wr_acc[wr_cnt]  = dut.acc;
      wr_cyc[wr_cnt]  = cyc;
      wr_cnt++;
    end
    if (done) begin
      done_cyc = cyc;
      done_cnt++;
    end
  end

  int checks = 0;
  int failures = 0;
  int base_w;
  int st;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [15:0] acts, input logic [15:0] w0, input logic [15:0] w1);
    for (int i = 0; i < 4; i++) begin
      act_mem[i]   = acts[4*i +: 4];
      w_mem[i]     = w0[4*i +: 4];
      w_mem[4 + i] = w1[4*i +: 4];
    end
  endtask

  // Pulse start; optionally pulse it again dup_at cycles later; wait for done.
  task automatic run_layer(input int dup_at, output int s);
    int base_d;
    base_w = wr_cnt;
    base_d = done_cnt;
    @(negedge clk);
    start = 1'b1;
    s = cyc;
    @(negedge clk);
    start = 1'b0;
    if (dup_at > 0) begin
      repeat (dup_at - 1) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    for (int i = 0; i < 200 && done_cnt == base_d; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    if (done_cnt == base_d) check("done_timeout", 0, 1);
  endtask

  task automatic check_run(input string tag, input int s, input logic [3:0] d0, input logic [3:0] d1);
    check({tag, "_wr_count"}, wr_cnt - base_w, 2);
    check({tag, "_addr0"}, wr_addr[base_w], 0);
    check({tag, "_addr1"}, wr_addr[base_w + 1], 1);
    check({tag, "_data0"}, wr_data[base_w], d0);
    check({tag, "_data1"}, wr_data[base_w + 1], d1);
    check({tag, "_first_wr_lat"}, wr_cyc[base_w] - s, 6);
    check({tag, "_wr_gap"}, wr_cyc[base_w + 1] - wr_cyc[base_w], 6);
    check({tag, "_done_lat"}, done_cyc - s, 13);
  endtask

  logic [3:0] e_p420, e_n480, e_n12, e_p12;

  initial begin
`ifdef LAYER_MAC_RELU_EN
    e_p420 = 4'd15; e_n480 = 4'd0; e_n12 = 4'd0; e_p12 = 4'd12;
`else
    e_p420 = 4'd7;  e_n480 = 4'b1000; e_n12 = 4'b1000; e_p12 = 4'd7;
`endif
    for (int i = 0; i < 16; i++) act_mem[i] = 4'd0;
    for (int i = 0; i < 256; i++) w_mem[i] = 4'd0;
    rst = 1'b1;
    start = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_w_en", o_w_en, 0);
    check("rst_r_addr", r_addr, 0);
    check("rst_w_rom_addr", w_rom_addr, 0);
    check("rst_o_w_addr", o_w_addr, 0);
    check("rst_o_data", o_data, 0);
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("idle_busy", busy, 0);

    // all ones: 4 per neuron
    load(16'h1111, 16'h1111, 16'h1111);
    run_layer(0, st);
    check_run("ones", st, 4'd4, 4'd4);
    check("ones_busy_after", busy, 0);

    // acts {1,2,3,4}; n0 w {2,-1,1,0} -> 3; n1 w {0,0,0,1} -> 4
    load(16'h4321, 16'h01F2, 16'h1000);
    run_layer(0, st);
    check_run("mixed", st, 4'd3, 4'd4);
    check("mixed_acc0", wr_acc[base_w], 16'd3);

    // acts 15; n0 w 7 -> 420; n1 w -8 -> -480
    load(16'hFFFF, 16'h7777, 16'h8888);
    run_layer(0, st);
    check_run("sat", st, e_p420, e_n480);
    check("sat_acc0", wr_acc[base_w], 16'h01A4);
    check("sat_acc1", wr_acc[base_w + 1], 16'hFE20);

    // acts 3; n0 w -1 -> -12; n1 w 1 -> 12
    load(16'h3333, 16'hFFFF, 16'h1111);
    run_layer(0, st);
    check_run("neg", st, e_n12, e_p12);
    check("neg_acc0", wr_acc[base_w], 16'hFFF4);

    // start during neuron 0 RUN is ignored
    load(16'h1111, 16'h1111, 16'h1111);
    run_layer(2, st);
    check_run("dup_start", st, 4'd4, 4'd4);
    run_layer(0, st);
    check_run("rerun", st, 4'd4, 4'd4);

    // reset during neuron 1 RUN
    base_w = wr_cnt;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    check("rst_mid_busy_before", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_done", done, 0);
    repeat (20) @(negedge clk);
    check("rst_mid_writes", wr_cnt - base_w, 1);
    check("rst_mid_done_after", done, 0);

    load(16'h4321, 16'h01F2, 16'h1000);
    run_layer(0, st);
    check_run("post_rst", st, 4'd3, 4'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
